// File: rtl/aes_subbytes_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module      : aes_subbytes_lane_pipe
// Description : Forward/inverse AES SubBytes over a 128-bit state. LANES
//               synchronous-read S-box ROMs are time-multiplexed over
//               P = 16/LANES passes per transaction. Valid/ready handshakes
//               are used on both sides, and a sideband tag travels with each
//               state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LANES      S-box ROM instances (bytes per pass): 1, 2, 4, 8 or 16
//   TAG_W      sideband tag width
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream presents a state
//   in_ready   block accepts a state this cycle (combinational from out_ready)
//   in_state   input state, byte 0 = in_state[127:120]
//   in_inv     1 = inverse S-box, 0 = forward S-box
//   in_tag     sideband, returned on out_tag
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_state  substituted state, same byte order as in_state
//   out_tag    tag of the result
//   busy       transaction in flight or waiting to be taken
// ============================================================================
module aes_subbytes_lane_pipe #(
   parameter int LANES = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_state,
   input  logic             in_inv,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_state,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int            P         = 16 / LANES;
   localparam int            PW        = (P > 1) ? $clog2(P) : 1;
   localparam logic [PW-1:0] LAST_PASS = PW'(P - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_subbytes_lane_pipe: LANES must be 1, 2, 4, 8 or 16");
   end

   // State viewed as P groups of LANES bytes; ascending ranges keep byte 0 in
   // the MSB position, so group[pass][lane] is byte pass*LANES+lane.
   typedef logic [0:P-1][0:LANES-1][7:0] grp_t;
   typedef logic [0:255][7:0]            tbl_t;

   localparam tbl_t SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // The inverse table is derived from the forward one so the two can never
   // disagree.
   function automatic tbl_t invert_tbl(input tbl_t fwd);
      tbl_t inv;
      inv = '0;
      for (int i = 0; i < 256; i++) begin
         inv[fwd[i]] = 8'(i);
      end
      return inv;
   endfunction

   localparam tbl_t SBOX_INV = invert_tbl(SBOX_FWD);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [PW-1:0]           pass_q, pass_d;
   logic                    drain_q, drain_d;   // last pass issued, waiting for its data
   logic                    rd_vld_q;           // ROM data from previous cycle is live
   logic [PW-1:0]           rd_pass_q;          // group that ROM data belongs to
   grp_t                    src_q;
   grp_t                    res_q, res_d;
   logic                    inv_q;
   logic [TAG_W-1:0]        tag_q;
   logic                    accept;
   logic                    issue;
   logic [7:0]              rom_q [LANES];
   logic [0:LANES-1][7:0]   rom_row;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   assign in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_state = res_q;
   assign out_tag   = tag_q;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      drain_d = drain_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RUN;
               pass_d  = '0;
               drain_d = 1'b0;
            end
         end
         S_RUN: begin
            if (drain_q) begin
               state_d = S_DONE;
               drain_d = 1'b0;
            end else begin
               issue = 1'b1;
               if (pass_q == LAST_PASS) begin
                  pass_d  = '0;
                  drain_d = 1'b1;
               end else begin
                  pass_d = pass_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               if (accept) begin
                  // Result leaves and the next state enters on the same edge.
                  state_d = S_RUN;
                  pass_d  = '0;
                  drain_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // S-box lanes: one synchronous-read ROM per lane
   // ------------------------------------------------------------------------
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      always_ff @(posedge clk) begin
         if (issue) begin
            rom_q[l] <= inv_q ? SBOX_INV[src_q[pass_q][l]] : SBOX_FWD[src_q[pass_q][l]];
         end
      end
      assign rom_row[l] = rom_q[l];
   end

   // Write-back lands one cycle after the pass that addressed the ROMs.
   always_comb begin
      res_d = res_q;
      if (rd_vld_q) begin
         res_d[rd_pass_q] = rom_row;
      end
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pass_q    <= '0;
         drain_q   <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_pass_q <= '0;
         res_q     <= '0;
         src_q     <= '0;
         inv_q     <= 1'b0;
         tag_q     <= '0;
      end else begin
         state_q   <= state_d;
         pass_q    <= pass_d;
         drain_q   <= drain_d;
         rd_vld_q  <= issue;
         rd_pass_q <= pass_q;
         res_q     <= res_d;
         if (accept) begin
            src_q <= in_state;
            inv_q <= in_inv;
            tag_q <= in_tag;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_subbytes_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_subbytes_lane_pipe
// Description : Self-checking bench for aes_subbytes_lane_pipe. One instance
//               per legal LANES value; results are compared against an S-box
//               model built from GF(2^8) arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_subbytes_lane_pipe;

   localparam int NI    = 5;   // instance k has LANES = 1 << k
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             in_valid  [NI];
   logic             in_ready  [NI];
   logic [127:0]     in_state  [NI];
   logic             in_inv    [NI];
   logic [TAG_W-1:0] in_tag    [NI];
   logic             out_valid [NI];
   logic             out_ready [NI];
   logic [127:0]     out_state [NI];
   logic [TAG_W-1:0] out_tag   [NI];
   logic             busy      [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      aes_subbytes_lane_pipe #(
         .LANES (1 << g),
         .TAG_W (TAG_W)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_state  (in_state[g]),
         .in_inv    (in_inv[g]),
         .in_tag    (in_tag[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g]),
         .out_tag   (out_tag[g]),
         .busy      (busy[g])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // ------------------------------------------------------------------------
   // Reference model: S-box from multiplicative inverse plus affine map
   // ------------------------------------------------------------------------
   logic [7:0] fwd_m [256];
   logic [7:0] inv_m [256];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_model();
      logic [7:0] x, s;
      for (int a = 0; a < 256; a++) begin
         x = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gf_mul(8'(a), 8'(b)) == 8'h01) x = 8'(b);
         end
         s = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
         fwd_m[a] = s;
         inv_m[s] = 8'(a);
      end
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic inv);
      logic [127:0] r;
      logic [7:0]   b;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         b = st[127-8*i -: 8];
         r[127-8*i -: 8] = inv ? inv_m[b] : fwd_m[b];
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ------------------------------------------------------------------------
   // Directed helpers (all driving and sampling around the falling edge)
   // ------------------------------------------------------------------------
   // Presents one state; returns at the falling edge right after acceptance.
   task automatic send(input int k, input logic [127:0] st, input logic inv,
                       input logic [TAG_W-1:0] tag, input logic rdy);
      @(negedge clk);
      in_state[k] = st; in_inv[k] = inv; in_tag[k] = tag;
      in_valid[k] = 1'b1; out_ready[k] = rdy;
      #1;
      check("in_ready_at_accept", 128'(in_ready[k]), 128'(1));
      @(negedge clk);
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      in_state[k] = rnd128(); in_inv[k] = ~inv; in_tag[k] = ~tag;
      #1;
   endtask

   // Counts edges after acceptance until out_valid; checks latency and data.
   task automatic wait_result(input int k, input logic [127:0] exp_st,
                              input logic [TAG_W-1:0] exp_tag, input int exp_lat);
      int n, idle_cnt;
      n = 0; idle_cnt = 0;
      while (!out_valid[k] && n < 40) begin
         if (!busy[k]) idle_cnt++;
         @(negedge clk); #1;
         n++;
      end
      check("latency", 128'(n), 128'(exp_lat));
      check("busy_while_run", 128'(idle_cnt), 128'(0));
      check("busy_done", 128'(busy[k]), 128'(1));
      check("out_state", out_state[k], exp_st);
      check("out_tag", 128'(out_tag[k]), 128'(exp_tag));
   endtask

   task automatic stall(input int k, input logic [127:0] exp_st,
                        input logic [TAG_W-1:0] exp_tag, input int cycles);
      repeat (cycles) begin
         @(negedge clk); out_ready[k] = 1'b0; #1;
         check("stall_valid", 128'(out_valid[k]), 128'(1));
         check("stall_state", out_state[k], exp_st);
         check("stall_tag", 128'(out_tag[k]), 128'(exp_tag));
         check("stall_in_ready", 128'(in_ready[k]), 128'(0));
      end
   endtask

   task automatic take(input int k);
      @(negedge clk); out_ready[k] = 1'b1; #1;
      @(negedge clk); out_ready[k] = 1'b0; #1;
      check("idle_valid", 128'(out_valid[k]), 128'(0));
      check("idle_busy", 128'(busy[k]), 128'(0));
   endtask

   // ------------------------------------------------------------------------
   // Randomised stream with random in_valid / out_ready
   // ------------------------------------------------------------------------
   typedef struct {
      logic [127:0]     s;
      logic [TAG_W-1:0] t;
   } exp_t;

   task automatic rand_stream(input int k, input int num);
      exp_t q[$];
      exp_t e;
      int   sent, got, cyc;
      logic pend;
      sent = 0; got = 0; cyc = 0; pend = 1'b0;
      while (got < num && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (!pend) begin
            if (sent < num && $urandom_range(2) != 0) begin
               in_state[k] = rnd128();
               in_inv[k]   = 1'($urandom_range(1));
               in_tag[k]   = TAG_W'($urandom);
               in_valid[k] = 1'b1;
               pend        = 1'b1;
            end else begin
               in_valid[k] = 1'b0;
               in_state[k] = rnd128();
            end
         end
         out_ready[k] = ($urandom_range(3) != 0);
         #1;
         if (out_valid[k]) begin
            if (q.size() == 0) begin
               check("rand_spurious_valid", 128'(1), 128'(0));
            end else if (out_ready[k]) begin
               e = q.pop_front();
               check("rand_state", out_state[k], e.s);
               check("rand_tag", 128'(out_tag[k]), 128'(e.t));
               got++;
            end else begin
               check("rand_hold_state", out_state[k], q[0].s);
               check("rand_hold_in_ready", 128'(in_ready[k]), 128'(0));
            end
         end
         if (in_valid[k] && in_ready[k]) begin
            q.push_back('{ref_sub(in_state[k], in_inv[k]), in_tag[k]});
            sent++;
            pend = 1'b0;
         end
      end
      check("rand_count", 128'(got), 128'(num));
      @(negedge clk);
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int seen;
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         in_valid[k] = 1'b0; in_state[k] = '0; in_inv[k] = 1'b0;
         in_tag[k] = '0; out_ready[k] = 1'b0;
      end
      build_model();

      // Reset state, including in_ready forced low while in reset
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check("rst_out_valid", 128'(out_valid[k]), 128'(0));
         check("rst_busy", 128'(busy[k]), 128'(0));
         check("rst_in_ready", 128'(in_ready[k]), 128'(0));
         check("rst_out_state", out_state[k], 128'(0));
         check("rst_out_tag", 128'(out_tag[k]), 128'(0));
      end
      @(negedge clk); rst_n = 1'b1; #1;
      for (int k = 0; k < NI; k++) check("post_rst_in_ready", 128'(in_ready[k]), 128'(1));

      // Forward vector, LANES=16
      send(4, 128'h00112233445566778899aabbccddeeff, 1'b0, 4'h5, 1'b0);
      wait_result(4, 128'h638293c31bfc33f5c4eeacea4bc12816, 4'h5, 2);
      take(4);

      // Inverse vector, LANES=4
      send(2, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 4'ha, 1'b0);
      wait_result(2, 128'h00112233445566778899aabbccddeeff, 4'ha, 5);
      take(2);

      // All-zero state, LANES=1, with backpressure and same-edge handoff
      send(0, 128'h0, 1'b0, 4'h3, 1'b0);
      wait_result(0, {16{8'h63}}, 4'h3, 17);
      stall(0, {16{8'h63}}, 4'h3, 10);
      send(0, 128'h0, 1'b1, 4'hc, 1'b1);
      wait_result(0, {16{8'h52}}, 4'hc, 17);
      take(0);

      // Same-edge handoff on LANES=8
      send(3, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0, 4'h1, 1'b0);
      wait_result(3, ref_sub(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0), 4'h1, 3);
      stall(3, ref_sub(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0), 4'h1, 2);
      send(3, 128'hffeeddccbbaa99887766554433221100, 1'b1, 4'h7, 1'b1);
      wait_result(3, ref_sub(128'hffeeddccbbaa99887766554433221100, 1'b1), 4'h7, 3);
      take(3);

      // Reset during pass 1 on LANES=4: transaction is discarded
      send(2, 128'h00112233445566778899aabbccddeeff, 1'b0, 4'h9, 1'b0);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; out_ready[2] = 1'b1; #1;
      check("midrst_out_valid", 128'(out_valid[2]), 128'(0));
      check("midrst_out_state", out_state[2], 128'(0));
      check("midrst_busy", 128'(busy[2]), 128'(0));
      check("midrst_in_ready", 128'(in_ready[2]), 128'(1));
      seen = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (out_valid[2] || busy[2]) seen++;
      end
      check("midrst_no_stale", 128'(seen), 128'(0));
      out_ready[2] = 1'b0;

      // Randomised streams on every LANES value
      for (int k = 0; k < NI; k++) rand_stream(k, 25);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
